// File: rtl/serial_pattern_feeder.sv
// rtl/serial_pattern_feeder.sv - parallel-to-serial word feeder with two-entry buffer
// Optional even-parity slot bit: define FEEDER_PARITY_EN.
module serial_pattern_feeder #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] word_i,
   input  logic             word_valid_i,
   output logic             word_ready_o,
   output logic             data_o,
   output logic             data_valid_o,
   output logic             busy_o
);

`ifdef FEEDER_PARITY_EN
   localparam int SLOT = WIDTH + 1;
`else
   localparam int SLOT = WIDTH;
`endif
   localparam int CW = $clog2(SLOT + 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] hold, hold_n;
   logic             hold_full, hold_full_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             data_n, data_valid_n;
   logic             xfer, last, load_pt;
   logic [WIDTH-1:0] load_word;
`ifdef FEEDER_PARITY_EN
   logic             par, par_n;
`endif

   assign word_ready_o = ~hold_full;
   assign busy_o       = (state == ST_SHIFT) | hold_full;
   assign xfer         = word_valid_i & ~hold_full;
   assign last         = (cnt == CW'(SLOT - 1));
   assign load_pt      = (state == ST_IDLE) | ((state == ST_SHIFT) & last);
   // A pending holding-register word always wins over the input port.
   assign load_word    = hold_full ? hold : word_i;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         cnt          <= '0;
         data_o       <= IDLE_LEVEL;
         data_valid_o <= 1'b0;
`ifdef FEEDER_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         shreg        <= shreg_n;
         hold         <= hold_n;
         hold_full    <= hold_full_n;
         cnt          <= cnt_n;
         data_o       <= data_n;
         data_valid_o <= data_valid_n;
`ifdef FEEDER_PARITY_EN
         par          <= par_n;
`endif
      end
   end

   always_comb begin
      state_n      = state;
      shreg_n      = shreg;
      hold_n       = hold;
      hold_full_n  = hold_full;
      cnt_n        = cnt;
      data_n       = data_o;
      data_valid_n = data_valid_o;
`ifdef FEEDER_PARITY_EN
      par_n        = par;
`endif
      if (load_pt) begin
         if (hold_full || xfer) begin
            // First bit goes straight to the output flop; the shifter keeps the rest.
            state_n      = ST_SHIFT;
            cnt_n        = '0;
            data_valid_n = 1'b1;
            hold_full_n  = 1'b0;
            if (MSB_FIRST) begin
               data_n  = load_word[WIDTH-1];
               shreg_n = load_word << 1;
            end else begin
               data_n  = load_word[0];
               shreg_n = load_word >> 1;
            end
`ifdef FEEDER_PARITY_EN
            par_n = ^load_word;
`endif
         end else begin
            state_n      = ST_IDLE;
            cnt_n        = '0;
            data_n       = IDLE_LEVEL;
            data_valid_n = 1'b0;
         end
      end else begin
         cnt_n = cnt + CW'(1);
`ifdef FEEDER_PARITY_EN
         if (cnt == CW'(WIDTH - 1)) begin
            data_n = par;
         end else if (MSB_FIRST) begin
            data_n  = shreg[WIDTH-1];
            shreg_n = shreg << 1;
         end else begin
            data_n  = shreg[0];
            shreg_n = shreg >> 1;
         end
`else
         if (MSB_FIRST) begin
            data_n  = shreg[WIDTH-1];
            shreg_n = shreg << 1;
         end else begin
            data_n  = shreg[0];
            shreg_n = shreg >> 1;
         end
`endif
         if (xfer) begin
            hold_n      = word_i;
            hold_full_n = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// tb/tb_serial_pattern_feeder.sv - scoreboard bench for serial_pattern_feeder
// Expected serial bits are queued at each accepted word; negedge monitors pop and compare.
module tb_serial_pattern_feeder;

`ifdef FEEDER_PARITY_EN
   localparam int SLOT = 9;
`else
   localparam int SLOT = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] word_m, word_l;
   logic       valid_m, valid_l;
   logic       ready_m, ready_l;
   logic       data_m, data_l;
   logic       dval_m, dval_l;
   logic       busy_m, busy_l;

   int total = 0;
   int bad   = 0;
   bit exp_m[$];
   bit exp_l[$];
   int run_m = 0, run_l = 0, last_m = 0, last_l = 0;

   always #5 clk = ~clk;

   serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
      .clk_i(clk), .reset_i(rst_n), .word_i(word_m), .word_valid_i(valid_m),
      .word_ready_o(ready_m), .data_o(data_m), .data_valid_o(dval_m), .busy_o(busy_m));

   serial_pattern_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
      .clk_i(clk), .reset_i(rst_n), .word_i(word_l), .word_valid_i(valid_l),
      .word_ready_o(ready_l), .data_o(data_l), .data_valid_o(dval_l), .busy_o(busy_l));

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (dval_m) begin
         run_m++;
         if (exp_m.size() == 0) chk("msb_unexpected_bit", 1, 0);
         else chk("msb_bit", int'(data_m), int'(exp_m.pop_front()));
      end else if (run_m != 0) begin
         last_m = run_m;
         run_m  = 0;
      end
   end

   always @(negedge clk) begin
      if (dval_l) begin
         run_l++;
         if (exp_l.size() == 0) chk("lsb_unexpected_bit", 1, 0);
         else chk("lsb_bit", int'(data_l), int'(exp_l.pop_front()));
      end else if (run_l != 0) begin
         last_l = run_l;
         run_l  = 0;
      end
   end

   // Returns with the accepting edge just passed (+1ns); valid stays asserted.
   task automatic send(input bit sel, input logic [7:0] w, output int waits);
      waits = 0;
      if (!sel) begin
         word_m = w; valid_m = 1'b1;
         while (!ready_m && waits < 50) begin @(posedge clk); #1; waits++; end
         chk("ready_seen_m", int'(ready_m), 1);
         @(posedge clk); #1;
         for (int i = 7; i >= 0; i--) exp_m.push_back(w[i]);
`ifdef FEEDER_PARITY_EN
         exp_m.push_back(^w);
`endif
      end else begin
         word_l = w; valid_l = 1'b1;
         while (!ready_l && waits < 50) begin @(posedge clk); #1; waits++; end
         chk("ready_seen_l", int'(ready_l), 1);
         @(posedge clk); #1;
         for (int i = 0; i < 8; i++) exp_l.push_back(w[i]);
`ifdef FEEDER_PARITY_EN
         exp_l.push_back(^w);
`endif
      end
   endtask

   task automatic wait_idle(input bit sel);
      int n = 0;
      while ((sel ? busy_l : busy_m) && n < 200) begin @(posedge clk); #1; n++; end
      chk("idle_reached", int'(sel ? busy_l : busy_m), 0);
      @(negedge clk); #1;
   endtask

   initial begin
      int w;
      int cnt;
      rst_n = 1'b0; valid_m = 1'b0; valid_l = 1'b0; word_m = '0; word_l = '0;
      #12;
      chk("rst_ready", int'(ready_m), 1);
      chk("rst_data", int'(data_m), 0);
      chk("rst_dval", int'(dval_m), 0);
      chk("rst_busy", int'(busy_m), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // single word A0: first bit in cycle 1, idle again after SLOT cycles
      send(1'b0, 8'hA0, w); valid_m = 1'b0;
      chk("t1_first_dval", int'(dval_m), 1);
      chk("t1_first_bit", int'(data_m), 1);
      repeat (SLOT) begin @(posedge clk); #1; end
      chk("t1_end_dval", int'(dval_m), 0);
      chk("t1_end_data", int'(data_m), 0);
      chk("t1_end_busy", int'(busy_m), 0);
      @(negedge clk); #1;
      chk("t1_run", last_m, SLOT);

      // streaming A5,5A,FF with valid held high
      send(1'b0, 8'hA5, w);
      send(1'b0, 8'h5A, w);
      chk("t2_wait2", w, 0);
      chk("t2_ready_low", int'(ready_m), 0);
      chk("t2_busy", int'(busy_m), 1);
      send(1'b0, 8'hFF, w);
      chk("t2_wait3", w, SLOT - 1);
      chk("t2_ready_low3", int'(ready_m), 0);
      valid_m = 1'b0;
      wait_idle(1'b0);
      chk("t2_run", last_m, 3 * SLOT);

      // LSB-first instance, word 01
      send(1'b1, 8'h01, w); valid_l = 1'b0;
      chk("t3_first_bit", int'(data_l), 1);
      wait_idle(1'b1);
      chk("t3_run", last_l, SLOT);

      // back-to-back A0 then 05
      send(1'b0, 8'hA0, w);
      send(1'b0, 8'h05, w); valid_m = 1'b0;
      wait_idle(1'b0);
      chk("t5_run", last_m, 2 * SLOT);

      // reset during bit 4 of FF
      send(1'b0, 8'hFF, w); valid_m = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("t4_mid_dval", int'(dval_m), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_async_data", int'(data_m), 0);
      chk("t4_async_dval", int'(dval_m), 0);
      chk("t4_async_busy", int'(busy_m), 0);
      exp_m.delete();
      @(negedge clk); rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin @(posedge clk); #1; if (dval_m) cnt++; end
      chk("t4_no_resume", cnt, 0);
      chk("t4_busy_after", int'(busy_m), 0);

      chk("q_empty_m", exp_m.size(), 0);
      chk("q_empty_l", exp_l.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
